seg7_scan_driver: RTL and testbench

Multiplexed driver for an N-digit common-anode 7-segment display. It holds a multi-digit display word and scans the digits in time-division. It decodes each digit to an active-low segment pattern: 0-9 always, A-F in hex mode. It also supports decimal points, leading-zero blanking and an anti-ghosting guard interval. It sits between the application logic and the board's segment/digit pins, and replaces per-digit static decoders.

---
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    hex_mode,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_blz;
    logic                    sh_hex;

    logic [4*NUM_DIGITS-1:0] ac_digits;
    logic [NUM_DIGITS-1:0]   ac_dp;
    logic                    ac_blz;
    logic                    ac_hex;

    logic                    slot_end;
    logic                    frame_end;
    logic                    in_guard;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic                    lz_sel;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [7:0]              pat;
    logic [7:0]              seg_nx;
    logic [NUM_DIGITS-1:0]   sel_nx;

    function automatic logic [7:0] decode(input logic [3:0] n, input logic hex);
        logic [7:0] p;
        case (n)
            4'h0: p = 8'hC0;
            4'h1: p = 8'hF9;
            4'h2: p = 8'hA4;
            4'h3: p = 8'hB0;
            4'h4: p = 8'h99;
            4'h5: p = 8'h92;
            4'h6: p = 8'h82;
            4'h7: p = 8'hF8;
            4'h8: p = 8'h80;
            4'h9: p = 8'h90;
            4'hA: p = hex ? 8'h88 : 8'hFF;
            4'hB: p = hex ? 8'h83 : 8'hFF;
            4'hC: p = hex ? 8'hC6 : 8'hFF;
            4'hD: p = hex ? 8'hA1 : 8'hFF;
            4'hE: p = hex ? 8'h86 : 8'hFF;
            default: p = hex ? 8'h8E : 8'hFF;
        endcase
        return p;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_guard  = (cnt < GUARD_C);

    always_comb begin
        nib    = 4'd0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        // A zero run from the top digit down is blanked; a dp or nonzero nibble stops it.
        lz_mask = '0;
        lz_run  = ac_blz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lz_run && (ac_digits[4*k +: 4] == 4'd0) && !ac_dp[k]) begin
                lz_mask[k] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = ac_digits[4*k +: 4];
                dp_sel = ac_dp[k];
                lz_sel = lz_mask[k];
            end
        end
        pat    = decode(nib, ac_hex);
        seg_nx = {~dp_sel, lz_sel ? 7'h7F : pat[6:0]};
        sel_nx = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blz     <= 1'b0;
            sh_hex     <= 1'b0;
            ac_digits  <= '0;
            ac_dp      <= '0;
            ac_blz     <= 1'b0;
            ac_hex     <= 1'b0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= 8'hFF;
            digit_sel  <= '1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_tick <= frame_end;
            seg        <= in_guard ? 8'hFF : seg_nx;
            digit_sel  <= in_guard ? '1 : sel_nx;

            // Active data only ever changes on the frame-end edge.
            if (load) begin
                if (frame_end) begin
                    ac_digits <= digits_in;
                    ac_dp     <= dp_in;
                    ac_blz    <= blank_lz;
                    ac_hex    <= hex_mode;
                    pending   <= 1'b0;
                end else begin
                    sh_digits <= digits_in;
                    sh_dp     <= dp_in;
                    sh_blz    <= blank_lz;
                    sh_hex    <= hex_mode;
                    pending   <= 1'b1;
                end
            end else if (frame_end && pending) begin
                ac_digits <= sh_digits;
                ac_dp     <= sh_dp;
                ac_blz    <= sh_blz;
                ac_hex    <= sh_hex;
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        hex_mode = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  digit_sel;
    logic        pending;
    logic        frame_tick;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .hex_mode(hex_mode),
        .seg(seg), .digit_sel(digit_sel), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame position p counts cycles within a frame; digit = p / SD, slot = p % SD.
    function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] dp,
                                           input logic blz, input logic hex, input int k);
        logic [7:0] tab [16];
        logic [7:0] s;
        int nb;
        int msd;
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        nb = (d >> (4 * k)) & 15;
        msd = 0;
        for (int j = 0; j < ND; j++)
            if ((((d >> (4 * j)) & 15) != 0) || dp[j]) msd = j;
        s = (nb <= 9 || hex) ? tab[nb] : 8'hFF;
        if (blz && k > msd) s[6:0] = 7'h7F;
        s[7] = ~dp[k];
        return s;
    endfunction

    int          p;
    logic [15:0] a_d, s_d;
    logic [3:0]  a_dp, s_dp;
    logic        a_blz, a_hex, s_blz, s_hex, m_pend;
    logic [7:0]  m_seg;
    logic [3:0]  m_sel;
    logic        m_ft;

    always @(posedge clk) begin : model
        bit fe;
        if (!rst_n) begin
            p = 0; a_d = 0; a_dp = 0; a_blz = 0; a_hex = 0;
            s_d = 0; s_dp = 0; s_blz = 0; s_hex = 0; m_pend = 0;
            m_seg = 8'hFF; m_sel = 4'hF; m_ft = 0;
        end else begin
            fe = (p == FRAME - 1);
            m_ft = fe;
            if ((p % SD) < GD) begin
                m_seg = 8'hFF; m_sel = 4'hF;
            end else begin
                m_seg = ref_seg(a_d, a_dp, a_blz, a_hex, p / SD);
                m_sel = ~(4'b0001 << (p / SD));
            end
            if (load && fe) begin
                a_d = digits_in; a_dp = dp_in; a_blz = blank_lz; a_hex = hex_mode; m_pend = 0;
            end else if (load) begin
                s_d = digits_in; s_dp = dp_in; s_blz = blank_lz; s_hex = hex_mode; m_pend = 1;
            end else if (fe && m_pend) begin
                a_d = s_d; a_dp = s_dp; a_blz = s_blz; a_hex = s_hex; m_pend = 0;
            end
            p = (p + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", seg, m_seg);
            check("model_digit_sel", digit_sel, m_sel);
            check("model_pending", pending, m_pend);
            check("model_frame_tick", frame_tick, m_ft);
        end
    end

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      dp;
        logic            blz;
        logic            hex;
        int              off;
        logic [3:0][7:0] e;
    } vec_t;

    vec_t vt [7];

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            checks++; errors++;
            $display("FAIL frame_tick_timeout actual=0 required=1 after %0d cycles", n);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic blz, input logic hex);
        digits_in = d; dp_in = dp; blank_lz = blz; hex_mode = hex; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic capture(input string name, input logic [3:0][7:0] e);
        logic [3:0][7:0] cap;
        cap = '0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            for (int k = 0; k < ND; k++)
                if (digit_sel == ~(4'b0001 << k)) cap[k] = seg;
        end
        for (int k = 0; k < ND; k++) check($sformatf("%s_digit%0d", name, k), cap[k], e[k]);
    endtask

    initial begin
        int n;
        vt[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, 2,  {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vt[1] = '{16'h00AF, 4'b0000, 1'b1, 1'b1, 2,  {8'hFF, 8'hFF, 8'h88, 8'h8E}};
        vt[2] = '{16'h00AF, 4'b0000, 1'b1, 1'b0, 5,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vt[3] = '{16'h0000, 4'b0100, 1'b1, 1'b0, 2,  {8'hFF, 8'h40, 8'hC0, 8'hC0}};
        vt[4] = '{16'h0000, 4'b0000, 1'b1, 1'b0, 9,  {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vt[5] = '{16'h5555, 4'b0000, 1'b0, 1'b0, 15, {8'h92, 8'h92, 8'h92, 8'h92}};
        vt[6] = '{16'hE07B, 4'b1001, 1'b0, 1'b1, 3,  {8'h06, 8'hC0, 8'hF8, 8'h03}};

        // Reset held three cycles
        rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_seg", seg, 8'hFF);
        check("rst_digit_sel", digit_sel, 4'hF);
        repeat (2) @(negedge clk);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_tick", frame_tick, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_seg", seg, 8'hFF);
        check("first_digit_sel", digit_sel, 4'hF);
        check("first_pending", pending, 1'b0);
        check("first_frame_tick", frame_tick, 1'b0);

        // Table-driven loads, each displayed in the frame after it is taken
        for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            repeat (vt[i].off) @(negedge clk);
            do_load(vt[i].d, vt[i].dp, vt[i].blz, vt[i].hex);
            check($sformatf("vec%0d_pending", i), pending, (vt[i].off == FRAME - 1) ? 1'b0 : 1'b1);
            wait_tick(n);
            check($sformatf("vec%0d_pending_clear", i), pending, 1'b0);
            capture($sformatf("vec%0d", i), vt[i].e);
        end

        // Frame period
        wait_tick(n);
        wait_tick(n);
        check("frame_period", n, FRAME);

        // Two loads in one frame: the later one wins
        wait_tick(n);
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'h0, 1'b0, 1'b0);
        check("double_load_pending", pending, 1'b1);
        wait_tick(n);
        capture("double_load", {8'hA4, 8'hA4, 8'hA4, 8'hA4});

        // Reset while data is pending discards it
        wait_tick(n);
        repeat (2) @(negedge clk);
        do_load(16'h9999, 4'h0, 1'b0, 1'b0);
        check("midrst_pending_before", pending, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_pending_after", pending, 1'b0);
        wait_tick(n);
        capture("midrst", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        // Random loads at random times, checked every cycle by the model
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            do_load(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (2 * FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
